fp_add_seq: RTL and testbench

Parametrised, multi-cycle floating-point adder/subtractor: the next generation of the team's 8-bit FPA core. Operand format (EXP_W, MAN_W) is a parameter, it supports subtraction, rounds to nearest-even, and handles specials explicitly. It uses a start/busy/done handshake and sits between the operand registers and the result/exception capture logic of the FPA datapath.

---
 rtl/fp_pkg.sv | 34 +++
 rtl/fp_align_shift.sv | 21 ++
 rtl/fp_add_seq.sv | 254 +++++++++++++++++++++++++
 tb/tb_fp_add_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared state encoding, exception bit positions and special-value constructors
// for the parametrised floating-point adder.
package fp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } fp_state_t;

    localparam int EXC_INVALID   = 3;
    localparam int EXC_OVERFLOW  = 2;
    localparam int EXC_UNDERFLOW = 1;
    localparam int EXC_ZERO      = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Positive infinity, right-aligned in a 64-bit word: {0, all-ones, 0...}.
    function automatic logic [63:0] fp_inf(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

    // Canonical quiet NaN: {0, all-ones, 100...}.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return fp_inf(exp_w, man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Right barrel shifter that reports whether any set bit fell off the bottom.
// Latency: combinational.
// Backpressure: none.
module fp_align_shift #(
    parameter int WIDTH = 7,
    parameter int SH_W  = 4
) (
    input  logic [WIDTH-1:0] din,
    input  logic [SH_W-1:0]  sh,
    output logic [WIDTH-1:0] dout,
    output logic             sticky
);

    logic [WIDTH-1:0] lost_mask;

    // Shifts of WIDTH or more give an all-ones mask, so everything lands in sticky.
    assign lost_mask = ~({WIDTH{1'b1}} << sh);
    assign dout      = din >> sh;
    assign sticky    = |(din & lost_mask);

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle FP add/sub, round-to-nearest-even, flush-to-zero, explicit specials.
// Latency: 5+k cycles from accepted start to done (k = left-normalise steps), 2 for specials.
// Backpressure: none; start is ignored unless idle, result held until the next done.
module fp_add_seq
    import fp_pkg::*;
#(
    parameter  int EXP_W = 4,
    parameter  int MAN_W = 3,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] ans,
    output logic [3:0]   ans_except,
    output logic         busy,
    output logic         done
);

    localparam int MW = MAN_W + 5;  // carry, hidden, fraction, G, R, S
    localparam int AW = MAN_W + 4;  // hidden, fraction, G, R, S

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W:0]   EXP_OVF  = {1'b0, EXP_ONES};
    localparam logic [EXP_W:0]   E_ONE    = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [W-1:0]     QNAN     = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [W-1:0]     INF_P    = W'(fp_inf(EXP_W, MAN_W));

    fp_state_t state, state_nxt;

    logic [W-1:0]     a_r, b_r;
    logic             op_r;
    logic             sign_gt, sign_ls;
    logic [EXP_W-1:0] exp_gt, exp_ls;
    logic [MAN_W:0]   man_gt, man_ls;
    logic             spec_vld, spec_inv;
    logic [W-1:0]     spec_res;
    logic [AW-1:0]    ls_al;
    logic [MW-1:0]    mw;
    logic [EXP_W:0]   ew;
    logic             sign_r;

    // Operand unpack (LOAD)
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             nan_a, nan_b, inf_a, inf_b, a_ge_b;
    logic             spec_hit, spec_inv_c;
    logic [W-1:0]     spec_res_c;

    always_comb begin
        sa = a_r[W-1];
        sb = b_r[W-1] ^ op_r;
        ea = a_r[W-2:MAN_W];
        eb = b_r[W-2:MAN_W];
        fa = (ea == '0) ? '0 : a_r[MAN_W-1:0];
        fb = (eb == '0) ? '0 : b_r[MAN_W-1:0];
        nan_a = (ea == EXP_ONES) && (fa != '0);
        nan_b = (eb == EXP_ONES) && (fb != '0);
        inf_a = (ea == EXP_ONES) && (fa == '0);
        inf_b = (eb == EXP_ONES) && (fb == '0);
        a_ge_b = {ea, fa} >= {eb, fb};
        spec_hit   = nan_a | nan_b | inf_a | inf_b;
        spec_inv_c = nan_a | nan_b | (inf_a & inf_b & (sa != sb));
        if (spec_inv_c)
            spec_res_c = QNAN;
        else if (inf_a)
            spec_res_c = {sa, INF_P[W-2:0]};
        else
            spec_res_c = {sb, INF_P[W-2:0]};
    end

    // Alignment (ALIGN)
    logic [AW-1:0] sh_dout;
    logic          sh_sticky;

    fp_align_shift #(
        .WIDTH (AW),
        .SH_W  (EXP_W)
    ) u_align (
        .din    ({man_ls, 3'b000}),
        .sh     (exp_gt - exp_ls),
        .dout   (sh_dout),
        .sticky (sh_sticky)
    );

    // Add / subtract (ADD)
    logic          eff_sub;
    logic [MW-1:0] gt_w, ls_w, add_sum;

    always_comb begin
        eff_sub = sign_gt ^ sign_ls;
        gt_w    = {1'b0, man_gt, 3'b000};
        ls_w    = {1'b0, ls_al};
        add_sum = eff_sub ? (gt_w - ls_w) : (gt_w + ls_w);
    end

    // Normalise decisions (NORM)
    logic n_carry, n_zero, n_uf, n_ok, norm_exit;

    always_comb begin
        n_carry   = mw[MW-1];
        n_zero    = (mw == '0);
        n_uf      = (ew == '0);
        n_ok      = mw[MW-2];
        norm_exit = n_carry | n_zero | n_uf | n_ok;
    end

    // Round and pack (ROUND)
    logic             rnd_up;
    logic [MAN_W+1:0] rnd_sum;
    logic [MAN_W-1:0] r_frac;
    logic [EXP_W:0]   r_exp;
    logic [W-1:0]     r_res;
    logic [3:0]       r_exc;

    always_comb begin
        rnd_up  = mw[2] & (mw[1] | mw[0] | mw[3]);
        rnd_sum = {1'b0, mw[MW-2:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
        // A rounding carry leaves 10..0, so the fraction is zero and the exponent steps up.
        if (rnd_sum[MAN_W+1]) begin
            r_frac = rnd_sum[MAN_W:1];
            r_exp  = ew + E_ONE;
        end else begin
            r_frac = rnd_sum[MAN_W-1:0];
            r_exp  = ew;
        end
        r_exc = '0;
        if (mw == '0) begin
            r_res           = {sign_r, {(W-1){1'b0}}};
            r_exc[EXC_ZERO] = 1'b1;
        end else if (ew == '0) begin
            r_res                = {sign_r, {(W-1){1'b0}}};
            r_exc[EXC_UNDERFLOW] = 1'b1;
            r_exc[EXC_ZERO]      = 1'b1;
        end else if (r_exp >= EXP_OVF) begin
            r_res               = {sign_r, INF_P[W-2:0]};
            r_exc[EXC_OVERFLOW] = 1'b1;
        end else begin
            r_res = {sign_r, r_exp[EXP_W-1:0], r_frac};
        end
    end

    // FSM
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_ALIGN;
            ST_ALIGN: state_nxt = spec_vld ? ST_DONE : ST_ADD;
            ST_ADD:   state_nxt = ST_NORM;
            ST_NORM:  if (norm_exit) state_nxt = ST_ROUND;
            ST_ROUND: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE) && (state != ST_DONE);
    assign done = (state == ST_DONE);

    // Datapath
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a_r        <= '0;
            b_r        <= '0;
            op_r       <= 1'b0;
            sign_gt    <= 1'b0;
            sign_ls    <= 1'b0;
            exp_gt     <= '0;
            exp_ls     <= '0;
            man_gt     <= '0;
            man_ls     <= '0;
            spec_vld   <= 1'b0;
            spec_inv   <= 1'b0;
            spec_res   <= '0;
            ls_al      <= '0;
            mw         <= '0;
            ew         <= '0;
            sign_r     <= 1'b0;
            ans        <= '0;
            ans_except <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_r  <= a;
                        b_r  <= b;
                        op_r <= op;
                    end
                end
                ST_LOAD: begin
                    spec_vld <= spec_hit;
                    spec_inv <= spec_inv_c;
                    spec_res <= spec_res_c;
                    if (a_ge_b) begin
                        sign_gt <= sa;
                        exp_gt  <= ea;
                        man_gt  <= {ea != '0, fa};
                        sign_ls <= sb;
                        exp_ls  <= eb;
                        man_ls  <= {eb != '0, fb};
                    end else begin
                        sign_gt <= sb;
                        exp_gt  <= eb;
                        man_gt  <= {eb != '0, fb};
                        sign_ls <= sa;
                        exp_ls  <= ea;
                        man_ls  <= {ea != '0, fa};
                    end
                end
                ST_ALIGN: begin
                    ls_al <= {sh_dout[AW-1:1], sh_dout[0] | sh_sticky};
                    if (spec_vld) begin
                        ans                     <= spec_res;
                        ans_except              <= '0;
                        ans_except[EXC_INVALID] <= spec_inv;
                    end
                end
                ST_ADD: begin
                    mw     <= add_sum;
                    ew     <= {1'b0, exp_gt};
                    // Exact cancellation is +0; an add of two zeros keeps their sign.
                    sign_r <= (eff_sub && add_sum == '0) ? 1'b0 : sign_gt;
                end
                ST_NORM: begin
                    if (n_carry) begin
                        mw <= {1'b0, mw[MW-1:2], mw[1] | mw[0]};
                        ew <= ew + E_ONE;
                    end else if (!norm_exit) begin
                        mw <= mw << 1;
                        ew <= ew - E_ONE;
                    end
                end
                ST_ROUND: begin
                    ans        <= r_res;
                    ans_except <= r_exc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed-vector scoreboard bench for fp_add_seq at EXP_W=4, MAN_W=3.
module tb_fp_add_seq;

    logic       clk = 1'b0;
    logic       clr_n, start, op;
    logic [7:0] a, b, ans;
    logic [3:0] ans_except;
    logic       busy, done;

    fp_add_seq dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .ans        (ans),
        .ans_except (ans_except),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         id;
        logic [7:0] ans;
        logic [3:0] exc;
        int         lat;
        int         t0;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   op_id = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check($sformatf("op%0d_ans", e.id), 32'(ans), 32'(e.ans));
                check($sformatf("op%0d_except", e.id), 32'(ans_except), 32'(e.exc));
                check($sformatf("op%0d_latency", e.id), 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after done.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic top,
                          input logic [7:0] eans, input logic [3:0] eexc, input int elat);
        int n;
        exp_t e;
        op_id++;
        e.id = op_id; e.ans = eans; e.exc = eexc; e.lat = elat; e.t0 = cyc + 1;
        sb_q.push_back(e);
        a = ta; b = tb_v; op = top; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("op%0d_busy", op_id), 32'(busy), 32'd1);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            check($sformatf("op%0d_timeout", op_id), 32'd0, 32'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        @(negedge clk);
        check($sformatf("op%0d_done_pulse", op_id), 32'(done), 32'd0);
        check($sformatf("op%0d_held", op_id), 32'({ans, ans_except}), 32'({eans, eexc}));
    endtask

    initial begin
        exp_t e;
        clr_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_ans", 32'(ans), 32'd0);
        check("rst_except", 32'(ans_except), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        clr_n = 1'b1;
        @(negedge clk);

        //      a      b      op    ans    exc    latency
        run_op(8'h38, 8'h3C, 1'b0, 8'h42, 4'h0, 5);  // 1.0+1.5, carry normalise
        run_op(8'h3C, 8'h38, 1'b1, 8'h30, 4'h0, 6);  // 1.5-1.0, k=1
        run_op(8'h98, 8'h13, 1'b0, 8'h8A, 4'h0, 7);  // -2^-4 + 1.375*2^-5, k=2
        run_op(8'h38, 8'h38, 1'b1, 8'h00, 4'h1, 5);  // exact cancel -> +0
        run_op(8'h77, 8'h77, 1'b0, 8'h78, 4'h4, 5);  // overflow
        run_op(8'h78, 8'hF8, 1'b0, 8'h7C, 4'h8, 2);  // inf + -inf
        run_op(8'h38, 8'h09, 1'b0, 8'h38, 4'h0, 5);  // sticky only
        run_op(8'h39, 8'h18, 1'b0, 8'h3A, 4'h0, 5);  // tie, odd -> up
        run_op(8'h38, 8'h18, 1'b0, 8'h38, 4'h0, 5);  // tie, even -> stays
        run_op(8'h38, 8'h19, 1'b0, 8'h39, 4'h0, 5);  // above half -> up
        run_op(8'h3F, 8'h18, 1'b0, 8'h40, 4'h0, 5);  // rounding carry renormalises
        run_op(8'h39, 8'h29, 1'b0, 8'h3B, 4'h0, 5);  // below half -> down
        run_op(8'h78, 8'h38, 1'b1, 8'h78, 4'h0, 2);  // inf - finite
        run_op(8'h38, 8'h78, 1'b1, 8'hF8, 4'h0, 2);  // finite - inf
        run_op(8'h79, 8'h38, 1'b0, 8'h7C, 4'h8, 2);  // NaN input
        run_op(8'h78, 8'h78, 1'b1, 8'h7C, 4'h8, 2);  // inf - inf
        run_op(8'h0A, 8'h09, 1'b1, 8'h00, 4'h3, 6);  // underflow
        run_op(8'h00, 8'h3C, 1'b0, 8'h3C, 4'h0, 5);  // zero + x
        run_op(8'h80, 8'h80, 1'b0, 8'h80, 4'h1, 5);  // -0 + -0
        run_op(8'h05, 8'h38, 1'b0, 8'h38, 4'h0, 5);  // subnormal flushed
        run_op(8'hB8, 8'h3C, 1'b1, 8'hC2, 4'h0, 5);  // -1.0 - 1.5

        // A second start while busy must be ignored.
        op_id++;
        e.id = op_id; e.ans = 8'h42; e.exc = 4'h0; e.lat = 5; e.t0 = cyc + 1;
        sb_q.push_back(e);
        a = 8'h38; b = 8'h3C; op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'h77; b = 8'h77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);

        // Reset in the middle of normalisation discards the operation.
        a = 8'h98; b = 8'h13; op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_clr_busy", 32'(busy), 32'd1);
        check("pre_clr_ans", 32'(ans), 32'h42);
        clr_n = 1'b0;
        #1;
        check("clr_ans", 32'(ans), 32'd0);
        check("clr_except", 32'(ans_except), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (12) @(negedge clk);
        run_op(8'h3C, 8'h38, 1'b1, 8'h30, 4'h0, 6);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
